// File: rtl/apu_reg_writer.sv
// apu_reg_writer: host-side initiator for the APU parallel register-write bus.
// Commands (address/data) arrive over a valid/ready handshake and are queued in
// a small circular FIFO. Each queued command is replayed as a timed
// setup / strobe / hold write cycle on the APU register bus.
//
// Optional build macro: APU_WR_COALESCE_EN
//   When defined, a push whose address matches the newest still-queued entry
//   overwrites that entry's data in place instead of enqueuing a new write.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   cmd_valid   command offered by the host
//   cmd_ready   command can be accepted this cycle
//   cmd_addr    target register address
//   cmd_data    register write value
//   bus_addr    APU register address (changes only on a FIFO pop)
//   bus_data    APU register data (changes only on a FIFO pop)
//   bus_we      APU write strobe, active high
//   busy        write in progress or commands still queued
//   fifo_count  number of commands currently buffered
module apu_reg_writer #(
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_data,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_data,
    output logic                   bus_we,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CYC_W-1:0]   cyc_q;
    logic [CYC_W-1:0]   cyc_d;

    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               coalesce;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == CNT_W'(0));
    assign fifo_count = count_q;

    // Sequencer: next state, cycle counter and pop decision
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cyc_q == CYC_W'(SETUP_CYCLES - 1)) begin
                    state_d = S_STROBE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_STROBE: begin
                if (cyc_q == CYC_W'(STROBE_CYCLES - 1)) begin
                    state_d = S_HOLD;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_HOLD: begin
                cyc_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
            end
        endcase
    end

`ifdef APU_WR_COALESCE_EN
    logic [PTR_W-1:0] newest_ptr;
    assign newest_ptr = wr_ptr_q - PTR_W'(1);

    // Merge into the newest queued entry; an entry leaving on this edge's pop
    // is already committed to the bus and must not be touched.
    always_comb begin
        coalesce  = 1'b0;
        cmd_ready = !full;
        if (cmd_valid && !empty && !(pop && (count_q == CNT_W'(1)))
            && (addr_mem[newest_ptr] == cmd_addr)) begin
            coalesce  = 1'b1;
            cmd_ready = 1'b1;
        end
    end
`else
    always_comb begin
        coalesce  = 1'b0;
        cmd_ready = !full;
    end
`endif

    // Occupancy update; a coalescing push does not add an entry
    always_comb begin
        push    = cmd_valid && cmd_ready && !coalesce;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage (no reset needed: pointers and count define validity)
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= cmd_addr;
            data_mem[wr_ptr_q] <= cmd_data;
        end
`ifdef APU_WR_COALESCE_EN
        else if (coalesce) begin
            data_mem[newest_ptr] <= cmd_data;
        end
`endif
    end

    // State, pointers and registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bus_addr <= '0;
            bus_data <= '0;
            bus_we   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                bus_addr <= addr_mem[rd_ptr_q];
                bus_data <= data_mem[rd_ptr_q];
            end
            bus_we <= (state_d == S_STROBE);
            busy   <= (state_d != S_IDLE) || (count_d != CNT_W'(0));
        end
    end

endmodule

// File: tb/tb_apu_reg_writer.sv
// Bench for apu_reg_writer at default parameters: single-write timing trace,
// back-to-back burst with FIFO full/wrap, same-address pushes and
// reset during a strobe. Bus writes are checked against a scoreboard queue.
module tb_apu_reg_writer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int          STROBE = 2;
    localparam int          PERIOD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              bus_we;
    logic              busy;
    logic [CNT_W-1:0]  fifo_count;

    always #5 clk = ~clk;

    apu_reg_writer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_we     (bus_we),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                len;
        int                cyc;
    } obs_t;

    // Per-cycle expected outputs after a single push from idle
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              we;
        logic              busy;
        logic [CNT_W-1:0]  cnt;
    } trace_t;

    // Burst push vector: command plus expected count after acceptance and stalls
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  exp_cnt;
        int                exp_stall;
    } vec_t;

    wr_t  exp_q[$];
    obs_t obs_q[$];
    int   obs_rd;
    int   n_checks;
    int   n_errors;
    int   cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: records each complete write (address, data, strobe length)
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_len;
    int                m_cyc;
    int                n_rises;
    logic              prev_we;

    initial begin
        prev_we = 1'b0;
        m_len   = 0;
        n_rises = 0;
        m_addr  = '0;
        m_data  = '0;
        m_cyc   = 0;
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
            m_len   = 0;
        end else begin
            if (bus_we) begin
                if (!prev_we) begin
                    n_rises = n_rises + 1;
                    m_addr  = bus_addr;
                    m_data  = bus_data;
                    m_cyc   = cyc;
                    m_len   = 0;
                end
                m_len = m_len + 1;
            end else if (prev_we) begin
                obs_q.push_back('{addr: m_addr, data: m_data, len: m_len, cyc: m_cyc});
            end
            prev_we = bus_we;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit merge, output int stalls,
                            output logic [CNT_W-1:0] stall_cnt,
                            output logic [CNT_W-1:0] cnt_after);
        bit ok;
        ok        = 1'b0;
        stalls    = 0;
        stall_cnt = '0;
        cnt_after = '0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 64 && !ok; i++) begin
            #1;
            if (cmd_ready) begin
                if (merge && exp_q.size() > 0)
                    exp_q[exp_q.size()-1] = '{addr: a, data: d};
                else
                    exp_q.push_back('{addr: a, data: d});
                @(posedge clk);
                #1;
                cnt_after = fifo_count;
                ok = 1'b1;
            end else begin
                stall_cnt = fifo_count;
                stalls    = stalls + 1;
                @(negedge clk);
            end
        end
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic stop_cmd();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 300) begin
            @(negedge clk);
            t = t + 1;
        end
        check("drain_in_time", 32'(t < 300), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Compare every expected write against recorded bus writes, in order
    task automatic compare_writes();
        while (exp_q.size() > 0) begin
            wr_t e;
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                check("wr_addr",   32'(obs_q[obs_rd].addr), 32'(e.addr));
                check("wr_data",   32'(obs_q[obs_rd].data), 32'(e.data));
                check("strobe_len", 32'(obs_q[obs_rd].len), 32'(STROBE));
            end else begin
                check("wr_missing", 32'(obs_q.size()), 32'(obs_rd + 1));
            end
            obs_rd = obs_rd + 1;
        end
        check("no_extra_writes", 32'(obs_q.size()), 32'(obs_rd));
        obs_rd = obs_q.size();
    endtask

    trace_t           trace [7];
    vec_t             vecs  [6];
    int               stalls;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] cnt_after;
    logic [CNT_W-1:0] peak;
    int               burst_start;
    int               rises_snap;

    initial begin
        trace[0] = '{addr: 4'h0, data: 8'h00, we: 1'b0, busy: 1'b1, cnt: 3'd1};
        trace[1] = '{addr: 4'h3, data: 8'h5A, we: 1'b0, busy: 1'b1, cnt: 3'd0};
        trace[2] = '{addr: 4'h3, data: 8'h5A, we: 1'b1, busy: 1'b1, cnt: 3'd0};
        trace[3] = '{addr: 4'h3, data: 8'h5A, we: 1'b1, busy: 1'b1, cnt: 3'd0};
        trace[4] = '{addr: 4'h3, data: 8'h5A, we: 1'b0, busy: 1'b1, cnt: 3'd0};
        trace[5] = '{addr: 4'h3, data: 8'h5A, we: 1'b0, busy: 1'b0, cnt: 3'd0};
        trace[6] = '{addr: 4'h3, data: 8'h5A, we: 1'b0, busy: 1'b0, cnt: 3'd0};

        vecs[0] = '{addr: 4'h4, data: 8'hA1, exp_cnt: 3'd1, exp_stall: 0};
        vecs[1] = '{addr: 4'h5, data: 8'hB2, exp_cnt: 3'd1, exp_stall: 0};
        vecs[2] = '{addr: 4'h6, data: 8'hC3, exp_cnt: 3'd2, exp_stall: 0};
        vecs[3] = '{addr: 4'h7, data: 8'hD4, exp_cnt: 3'd3, exp_stall: 0};
        vecs[4] = '{addr: 4'h8, data: 8'hE5, exp_cnt: 3'd4, exp_stall: 0};
        vecs[5] = '{addr: 4'h9, data: 8'hF6, exp_cnt: 3'd4, exp_stall: 1};

        n_checks  = 0;
        n_errors  = 0;
        obs_rd    = 0;
        cyc       = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        check("rst_bus_we",     32'(bus_we),     32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_bus_addr",   32'(bus_addr),   32'd0);
        check("rst_bus_data",   32'(bus_data),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single write: cycle-by-cycle trace after push at edge T
        cmd_valid = 1'b1;
        cmd_addr  = 4'h3;
        cmd_data  = 8'h5A;
        #1;
        check("single_ready", 32'(cmd_ready), 32'd1);
        exp_q.push_back('{addr: 4'h3, data: 8'h5A});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
            check($sformatf("trace%0d_addr", i), 32'(bus_addr),   32'(trace[i].addr));
            check($sformatf("trace%0d_data", i), 32'(bus_data),   32'(trace[i].data));
            check($sformatf("trace%0d_we",   i), 32'(bus_we),     32'(trace[i].we));
            check($sformatf("trace%0d_busy", i), 32'(busy),       32'(trace[i].busy));
            check($sformatf("trace%0d_cnt",  i), 32'(fifo_count), 32'(trace[i].cnt));
        end
        drain();
        compare_writes();

        // Back-to-back burst: fills FIFO, stalls the last push, wraps pointers
        burst_start = obs_q.size();
        for (int i = 0; i < 6; i++) begin
            push_cmd(vecs[i].addr, vecs[i].data, 1'b0, stalls, stall_cnt, cnt_after);
            check($sformatf("burst%0d_cnt", i),   32'(cnt_after), 32'(vecs[i].exp_cnt));
            check($sformatf("burst%0d_stall", i), 32'(stalls),    32'(vecs[i].exp_stall));
            if (vecs[i].exp_stall > 0)
                check($sformatf("burst%0d_stall_cnt", i), 32'(stall_cnt), 32'd4);
        end
        stop_cmd();
        drain();
        compare_writes();
        check("burst_writes", 32'(obs_q.size() - burst_start), 32'd6);
        for (int k = burst_start + 1; k < obs_q.size(); k++)
            check($sformatf("spacing%0d", k - burst_start),
                  32'(obs_q[k].cyc - obs_q[k-1].cyc), 32'(PERIOD));
        check("burst_idle_busy", 32'(busy), 32'd0);

        // Same-address pushes while the first is still queued
        peak = '0;
        push_cmd(4'h1, 8'h33, 1'b0, stalls, stall_cnt, cnt_after);
        if (cnt_after > peak) peak = cnt_after;
        push_cmd(4'h2, 8'h11, 1'b0, stalls, stall_cnt, cnt_after);
        if (cnt_after > peak) peak = cnt_after;
`ifdef APU_WR_COALESCE_EN
        push_cmd(4'h2, 8'h22, 1'b1, stalls, stall_cnt, cnt_after);
        if (cnt_after > peak) peak = cnt_after;
        stop_cmd();
        check("coalesce_peak", 32'(peak), 32'd1);
`else
        push_cmd(4'h2, 8'h22, 1'b0, stalls, stall_cnt, cnt_after);
        if (cnt_after > peak) peak = cnt_after;
        stop_cmd();
        check("nocoalesce_peak", 32'(peak), 32'd2);
`endif
        drain();
        compare_writes();

        // Reset while the strobe is high
        push_cmd(4'hA, 8'h77, 1'b0, stalls, stall_cnt, cnt_after);
        push_cmd(4'hB, 8'h88, 1'b0, stalls, stall_cnt, cnt_after);
        push_cmd(4'hC, 8'h99, 1'b0, stalls, stall_cnt, cnt_after);
        stop_cmd();
        for (int i = 0; i < 40 && bus_we !== 1'b1; i++) @(negedge clk);
        check("mid_we_high", 32'(bus_we), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_we",     32'(bus_we),     32'd0);
        check("mid_rst_count",  32'(fifo_count), 32'd0);
        check("mid_rst_busy",   32'(busy),       32'd0);
        check("mid_rst_ready",  32'(cmd_ready),  32'd1);
        check("mid_rst_addr",   32'(bus_addr),   32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        obs_rd     = obs_q.size();
        rises_snap = n_rises;
        repeat (20) @(negedge clk);
        check("post_rst_no_writes", 32'(n_rises),    32'(rises_snap));
        check("post_rst_busy",      32'(busy),       32'd0);
        check("post_rst_count",     32'(fifo_count), 32'd0);
        check("post_rst_addr",      32'(bus_addr),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
